// File: rtl/uart_tx.sv
// uart_tx: tick-driven UART frame serialiser (start, LSB-first data, optional parity, stop).
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx #(
  parameter int OVERSAMPLING = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tick,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy
);
  localparam int TW = $clog2(OVERSAMPLING);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_e;
  state_e state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic tx_q, tx_d;
  logic xfer, adv;
  assign xfer = state_q == IDLE && i_valid;
  assign adv = state_q != IDLE && i_tick && tick_q == TICK_LAST;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end
`ifdef UART_TX_PARITY_EN
  logic par_q;
  // parity is taken from the byte as latched, before any shifting
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) par_q <= 1'b0;
    else if (xfer) par_q <= ^i_data ^ 1'(PARITY_ODD);
  end
`else
  logic unused_par_odd;
  assign unused_par_odd = 1'(PARITY_ODD);
`endif
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (xfer) begin
      state_d = START;
      tick_d  = '0;
      bit_d   = '0;
      shift_d = i_data;
    end else if (state_q != IDLE && i_tick) begin
      tick_d = adv ? '0 : tick_q + 1'b1;
      if (adv) begin
        case (state_q)
          START: state_d = DATA;
          DATA: begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q == DATA_LAST ? '0 : bit_q + 1'b1;
`ifdef UART_TX_PARITY_EN
            if (bit_q == DATA_LAST) state_d = PARITY;
          end
          PARITY: state_d = STOP;
`else
            if (bit_q == DATA_LAST) state_d = STOP;
          end
`endif
          STOP: begin
            bit_d = bit_q == STOP_LAST ? '0 : bit_q + 1'b1;
            if (bit_q == STOP_LAST) state_d = IDLE;
          end
          default: state_d = state_q;
        endcase
      end
    end
  end
  // line level follows the next state so the registered output never glitches
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end
  assign o_ready = state_q == IDLE;
  assign o_busy  = !o_ready;
  assign o_tx    = tx_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with OVERSAMPLING=4 and a tick every 3rd clock.
`timescale 1ns/1ps
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
  localparam int FN = 11;
`else
  localparam int FN = 10;
`endif
  logic clk = 0, rst_n = 0, tick = 0, tick_en = 1, valid = 0;
  logic [7:0] data = 8'h00;
  logic [1:0] div = 2'd0;
  logic tx, ready, busy;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!tick_en) begin
      div  <= 2'd0;
      tick <= 1'b0;
    end else begin
      div  <= div == 2'd2 ? 2'd0 : div + 2'd1;
      tick <= div == 2'd1;
    end
  end

  uart_tx #(.OVERSAMPLING(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_tx(tx), .o_busy(busy)
  );
`ifdef UART_TX_PARITY_EN
  logic tx_odd, ready_odd, busy_odd;
  uart_tx #(.OVERSAMPLING(4), .PARITY_ODD(1)) dut_odd (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_data(data), .i_valid(valid),
    .o_ready(ready_odd), .o_tx(tx_odd), .o_busy(busy_odd)
  );
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b0, 1'b1, ^d, d, 1'b0};
`else
    return {2'b00, 1'b1, d, 1'b0};
`endif
  endfunction

  task automatic wait_tick(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic stall();
    logic v;
    tick_en = 1'b0;
    v = tx;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("stall_hold", tx, v);
      if (i == 10 || i == 30) begin
        valid = 1'b1;
        data = 8'hFF;
      end else valid = 1'b0;
    end
    chk("stall_busy", ready, 1'b0);
    tick_en = 1'b1;
  endtask

  task automatic check_frame(input logic [11:0] bits, input int stall_bit);
    logic ok;
    for (int k = 0; k < FN; k++) begin
      for (int t = 0; t < 4; t++) begin
        wait_tick(ok);
        chk("tick_timeout", ok, 1'b1);
        chk($sformatf("bit%0d_t%0d", k, t), tx, bits[k]);
`ifdef UART_TX_PARITY_EN
        chk($sformatf("odd_bit%0d", k), tx_odd, k == 9 ? ~bits[k] : bits[k]);
`endif
        if (k == stall_bit && t == 1) stall();
      end
    end
    chk("busy_last_stop", busy, 1'b1);
    @(negedge clk);
    chk("ready_after", ready, 1'b1);
    chk("busy_after", busy, 1'b0);
    chk("tx_after", tx, 1'b1);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    chk("ready_before", ready, 1'b1);
    valid = 1'b1;
    data = d;
    @(posedge clk);
    #1;
    valid = 1'b0;
    data = 8'($urandom);
    chk("start_tx", tx, 1'b0);
    chk("start_ready", ready, 1'b0);
    chk("start_busy", busy, 1'b1);
  endtask

  initial begin
    logic ok;
    repeat (5) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", ready, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_tx", tx, 1'b1);
      chk("idle_ready", ready, 1'b1);
      chk("idle_busy", busy, 1'b0);
    end
    send(8'hA5);
    check_frame(frame(8'hA5), -1);
    send(8'h07);
    check_frame(frame(8'h07), -1);
    // back-to-back with valid held high
    @(negedge clk);
    valid = 1'b1;
    data = 8'h00;
    @(posedge clk);
    #1;
    data = 8'hFF;
    chk("b2b_start0", tx, 1'b0);
    check_frame(frame(8'h00), -1);
    @(posedge clk);
    #1;
    chk("b2b_xfer_ready", ready, 1'b0);
    chk("b2b_start1", tx, 1'b0);
    valid = 1'b0;
    check_frame(frame(8'hFF), -1);
    // async reset during data bit 3
    send(8'hF0);
    for (int i = 0; i < 18; i++) wait_tick(ok);
    chk("pre_reset_bit3", tx, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_ready", ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(8'h3C);
    check_frame(frame(8'h3C), -1);
    // tick stall mid data bit 3 with valid pulses while busy
    send(8'h5A);
    check_frame(frame(8'h5A), 4);
    repeat (30) @(negedge clk);
    chk("no_extra_tx", tx, 1'b1);
    chk("no_extra_ready", ready, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
